// File: rtl/rs_alu_issue.sv
// ALU reservation station: buffers dispatched instructions, captures CDB operands, and issues
// the lowest-index ready entry per cycle through a registered output stage.
module rs_alu_issue #(
    parameter int unsigned RS_SIZE  = 8,
    parameter int unsigned ROB_ID_W = 4,
    parameter int unsigned OPTYPE_W = 6
) (
    input  logic                clk_in,
    input  logic                rstn_in,
    input  logic                rdy_in,
    input  logic                flush_in,
    input  logic                disp_valid,
    input  logic [OPTYPE_W-1:0] disp_optype,
    input  logic [31:0]         disp_pc,
    input  logic [31:0]         disp_imm,
    input  logic [ROB_ID_W-1:0] disp_rd_alias,
    input  logic                disp_qj_busy,
    input  logic [ROB_ID_W-1:0] disp_qj,
    input  logic [31:0]         disp_vj,
    input  logic                disp_qk_busy,
    input  logic [ROB_ID_W-1:0] disp_qk,
    input  logic [31:0]         disp_vk,
    input  logic                alu_cdb_valid,
    input  logic [ROB_ID_W-1:0] alu_cdb_alias,
    input  logic [31:0]         alu_cdb_data,
    input  logic                lsb_cdb_valid,
    input  logic [ROB_ID_W-1:0] lsb_cdb_alias,
    input  logic [31:0]         lsb_cdb_data,
    output logic                rs_full,
    output logic [OPTYPE_W-1:0] alu_optype,
    output logic [ROB_ID_W-1:0] alu_rd_alias,
    output logic [31:0]         alu_pc,
    output logic [31:0]         alu_rs1,
    output logic [31:0]         alu_rs2,
    output logic [31:0]         alu_imm
);

    localparam int unsigned IDX_W = $clog2(RS_SIZE);

    typedef struct packed {
        logic                valid;
        logic [OPTYPE_W-1:0] optype;
        logic [31:0]         pc;
        logic [31:0]         imm;
        logic [ROB_ID_W-1:0] rd_alias;
        logic                qj_busy;
        logic [ROB_ID_W-1:0] qj;
        logic [31:0]         vj;
        logic                qk_busy;
        logic [ROB_ID_W-1:0] qk;
        logic [31:0]         vk;
    } entry_t;

    entry_t ent_q [RS_SIZE];
    entry_t ent_d [RS_SIZE];
    entry_t new_ent;

    logic [OPTYPE_W-1:0] optype_q, optype_d;
    logic [ROB_ID_W-1:0] rd_alias_q, rd_alias_d;
    logic [31:0]         pc_q, pc_d, rs1_q, rs1_d, rs2_q, rs2_d, imm_q, imm_d;

    logic             free_found, issue_found;
    logic [IDX_W-1:0] free_idx, issue_idx;

    // Lowest-index free slot and lowest-index ready entry, both from registered state only.
    always_comb begin
        free_found  = 1'b0;
        free_idx    = '0;
        issue_found = 1'b0;
        issue_idx   = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (!free_found && !ent_q[i].valid) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (!issue_found && ent_q[i].valid && !ent_q[i].qj_busy && !ent_q[i].qk_busy) begin
                issue_found = 1'b1;
                issue_idx   = IDX_W'(i);
            end
        end
    end

    assign rs_full = !free_found;

    // Incoming entry with same-cycle CDB capture; the ALU port wins a dual match.
    always_comb begin
        new_ent          = '0;
        new_ent.valid    = 1'b1;
        new_ent.optype   = disp_optype;
        new_ent.pc       = disp_pc;
        new_ent.imm      = disp_imm;
        new_ent.rd_alias = disp_rd_alias;
        new_ent.qj_busy  = disp_qj_busy;
        new_ent.qj       = disp_qj;
        new_ent.vj       = disp_vj;
        new_ent.qk_busy  = disp_qk_busy;
        new_ent.qk       = disp_qk;
        new_ent.vk       = disp_vk;
        if (disp_qj_busy) begin
            if (alu_cdb_valid && alu_cdb_alias == disp_qj) begin
                new_ent.qj_busy = 1'b0;
                new_ent.vj      = alu_cdb_data;
            end else if (lsb_cdb_valid && lsb_cdb_alias == disp_qj) begin
                new_ent.qj_busy = 1'b0;
                new_ent.vj      = lsb_cdb_data;
            end
        end
        if (disp_qk_busy) begin
            if (alu_cdb_valid && alu_cdb_alias == disp_qk) begin
                new_ent.qk_busy = 1'b0;
                new_ent.vk      = alu_cdb_data;
            end else if (lsb_cdb_valid && lsb_cdb_alias == disp_qk) begin
                new_ent.qk_busy = 1'b0;
                new_ent.vk      = lsb_cdb_data;
            end
        end
    end

    always_comb begin
        ent_d       = ent_q;
        optype_d    = optype_q;
        rd_alias_d  = rd_alias_q;
        pc_d        = pc_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        imm_d       = imm_q;
        if (rdy_in) begin
            if (flush_in) begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    ent_d[i].valid = 1'b0;
                end
                optype_d = '0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (ent_q[i].valid && ent_q[i].qj_busy) begin
                        if (alu_cdb_valid && alu_cdb_alias == ent_q[i].qj) begin
                            ent_d[i].qj_busy = 1'b0;
                            ent_d[i].vj      = alu_cdb_data;
                        end else if (lsb_cdb_valid && lsb_cdb_alias == ent_q[i].qj) begin
                            ent_d[i].qj_busy = 1'b0;
                            ent_d[i].vj      = lsb_cdb_data;
                        end
                    end
                    if (ent_q[i].valid && ent_q[i].qk_busy) begin
                        if (alu_cdb_valid && alu_cdb_alias == ent_q[i].qk) begin
                            ent_d[i].qk_busy = 1'b0;
                            ent_d[i].vk      = alu_cdb_data;
                        end else if (lsb_cdb_valid && lsb_cdb_alias == ent_q[i].qk) begin
                            ent_d[i].qk_busy = 1'b0;
                            ent_d[i].vk      = lsb_cdb_data;
                        end
                    end
                end
                if (issue_found) begin
                    ent_d[issue_idx].valid = 1'b0;
                    optype_d   = ent_q[issue_idx].optype;
                    rd_alias_d = ent_q[issue_idx].rd_alias;
                    pc_d       = ent_q[issue_idx].pc;
                    rs1_d      = ent_q[issue_idx].vj;
                    rs2_d      = ent_q[issue_idx].vk;
                    imm_d      = ent_q[issue_idx].imm;
                end else begin
                    optype_d = '0;
                end
                // The free slot is never the issuing slot, so both writes can coexist.
                if (disp_valid && free_found) begin
                    ent_d[free_idx] = new_ent;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                ent_q[i] <= '0;
            end
            optype_q   <= '0;
            rd_alias_q <= '0;
            pc_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            imm_q      <= '0;
        end else begin
            ent_q      <= ent_d;
            optype_q   <= optype_d;
            rd_alias_q <= rd_alias_d;
            pc_q       <= pc_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            imm_q      <= imm_d;
        end
    end

    assign alu_optype   = optype_q;
    assign alu_rd_alias = rd_alias_q;
    assign alu_pc       = pc_q;
    assign alu_rs1      = rs1_q;
    assign alu_rs2      = rs2_q;
    assign alu_imm      = imm_q;

endmodule

// File: doc/rs_alu_issue.md
Name: rs_alu_issue

Overview:
Reservation station feeding the integer ALU. It buffers dispatched non-memory instructions and captures operands broadcast on the two CDB ports (ALU, LSB). Each cycle it issues at most one operand-ready entry to the ALU through a registered output stage. Sits between dispatch/decode and the combinational ALU.

Parameters:
RS_SIZE, 8, number of entries (power of 2, >=2)
ROB_ID_W, 4, ROB alias width
OPTYPE_W, 6, optype encoding width; value 0 is NOP

Ports:
clk_in  in  1  clock
rstn_in  in  1  asynchronous active-low reset
rdy_in  in  1  global ready; 0 freezes all state and outputs
flush_in  in  1  mispredict clear
disp_valid  in  1  dispatch request
disp_optype  in  OPTYPE_W  instruction optype
disp_pc  in  32  instruction pc
disp_imm  in  32  immediate
disp_rd_alias  in  ROB_ID_W  destination ROB id
disp_qj_busy  in  1  rs1 pending
disp_qj  in  ROB_ID_W  rs1 producer alias
disp_vj  in  32  rs1 value (valid when qj_busy=0)
disp_qk_busy  in  1  rs2 pending
disp_qk  in  ROB_ID_W  rs2 producer alias
disp_vk  in  32  rs2 value
alu_cdb_valid  in  1  ALU broadcast valid
alu_cdb_alias  in  ROB_ID_W  ALU broadcast alias
alu_cdb_data  in  32  ALU broadcast result
lsb_cdb_valid  in  1  LSB broadcast valid
lsb_cdb_alias  in  ROB_ID_W  LSB broadcast alias
lsb_cdb_data  in  32  LSB broadcast result
rs_full  out  1  no free entry
alu_optype  out  OPTYPE_W  issued optype (0 = NOP)
alu_rd_alias  out  ROB_ID_W  issued ROB id
alu_pc  out  32  issued pc
alu_rs1  out  32  issued rs1 value
alu_rs2  out  32  issued rs2 value
alu_imm  out  32  issued immediate

Behaviour:
- Reset (rstn_in=0, async): all entry valid bits 0; all alu_* outputs 0 (optype NOP); rs_full=0.
- rdy_in=0: no state or output change; all inputs ignored.
- Entry fields: valid, optype, pc, imm, rd_alias, qj_busy/qj/vj, qk_busy/qk/vk.
- rs_full: combinational, 1 iff all RS_SIZE entries valid (current state only; an issue in the same cycle does not free a slot for dispatch).
- Dispatch: when disp_valid & !rs_full & !flush_in, write into lowest-index free entry at clock edge. If either CDB port is valid in that cycle with alias equal to a busy disp_qj/disp_qk, store the CDB data with busy=0 (same-cycle capture). If both ports match, ALU port wins. disp_valid while full: dropped (dispatcher must honour rs_full).
- Wakeup: each edge, every valid entry with busy qj (qk) matching a valid CDB alias takes the data and clears busy. ALU port has priority on a dual match.
- Ready = valid & !qj_busy & !qk_busy, evaluated on registered state. An entry woken at edge t is issue-eligible in the cycle after t (no CDB bypass into issue select).
- Issue: each cycle, the lowest-index ready entry loads the output registers and its valid bit clears at the same edge. If none ready, alu_optype <= 0; other alu_* outputs hold their previous values. Latency dispatch-with-ready-operands -> alu_optype nonzero: 2 edges (write, then issue).
- An entry may be issued and a new dispatch may be written into a different free slot in the same cycle. A freed slot is reusable from the next cycle.
- flush_in=1 (rdy_in=1): at the edge, all valid bits clear and alu_optype <= 0. Dispatch and issue in that cycle are suppressed. Flush takes priority over everything except reset.
- Reset asserted mid-operation: immediate clear as at reset; no partial issue is visible.
- Widths: aliases compared on full ROB_ID_W; no arithmetic beyond priority encode.

Test Plan:
- Reset: hold rstn_in=0 with disp_valid=1 -> alu_optype=0, rs_full=0; after release, first ready dispatch (ADDI, rd_alias=3, vj=5, imm=7) appears on ALU two edges later with rs1=5, imm=7, rd_alias=3.
- Wakeup: dispatch ADD with qj_busy=1, qj=2, vk=10; two cycles later alu_cdb_valid=1, alias=2, data=0x20 -> ADD issues on the following edge with rs1=0x20, rs2=10.
- Same-cycle capture: dispatch with qk_busy=1, qk=5 while lsb_cdb_valid=1, alias=5, data=0xAB -> entry ready immediately; issues next edge with rs2=0xAB. Dual match (ALU data 1, LSB data 2) -> captures 1.
- Full: fill 8 entries all waiting on alias 9 -> rs_full=1; a 9th dispatch is dropped; broadcast alias 9 -> entries issue one per cycle in index order 0..7, exactly 8 issues, then NOP.
- Flush: 4 pending entries plus a same-cycle dispatch with flush_in=1 -> next cycle all slots free, alu_optype=0, rs_full=0, no later issue of the flushed instructions.
- rdy_in=0 for 3 cycles mid-stream with a CDB pulse -> outputs and entries unchanged, pulse not captured; resume continues the issue order exactly.
